opl2_timer_status: RTL and testbench



---
 rtl/opl2_timer_status.sv | 106 ++++++++++
 tb/tb_opl2_timer_status.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/opl2_timer_status.sv
// rtl/opl2_timer_status.sv - OPL2 timer registers, timers, overflow flags, status byte and IRQ.
// Optional feature macro: OPL2_FORCE_OVERFLOW_EN (force_timer_overflow sets unmasked flags).
package opl2_timer_pkg;
  localparam int REG_FILE_DATA_WIDTH = 8;

  typedef struct packed {
    logic       valid;
    logic [7:0] address;
    logic [7:0] data;
  } opl2_reg_wr_t;
endpackage

module opl2_timer_status
  import opl2_timer_pkg::*;
#(
  parameter int CLK_DIV_80US  = 288,
  parameter int T2_TICK_RATIO = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  opl2_reg_wr_t                   opl2_reg_wr,
  input  logic                           force_timer_overflow,
  output logic [REG_FILE_DATA_WIDTH-1:0] status,
  output logic                           irq_n,
  output logic                           t1_tick
);

  localparam logic [11:0] PRE_LAST = 12'(CLK_DIV_80US - 1);
  localparam logic [3:0]  SUB_LAST = 4'(T2_TICK_RATIO - 1);

  logic [11:0] pre;
  logic [3:0]  sub;
  logic        t2_tick;
  logic [7:0]  t1_reload, t2_reload, cnt1, cnt2;
  logic        mask1, mask2, st1, st2, ft1, ft2;
  logic        wr_ctl, wr_clr, wr_mode;
  logic        start1, start2, ov1, ov2, force_set;
  logic        ft1_next, ft2_next;

  assign t1_tick = (pre == PRE_LAST);
  assign t2_tick = t1_tick && (sub == SUB_LAST);

  assign wr_ctl  = opl2_reg_wr.valid && (opl2_reg_wr.address == 8'h04);
  assign wr_clr  = wr_ctl && opl2_reg_wr.data[7];
  assign wr_mode = wr_ctl && !opl2_reg_wr.data[7];

  // A start edge only exists while the timer is stopped, so it never coincides with a tick update.
  assign start1 = wr_mode && opl2_reg_wr.data[0] && !st1;
  assign start2 = wr_mode && opl2_reg_wr.data[1] && !st2;
  assign ov1    = st1 && t1_tick && (cnt1 == 8'hFF);
  assign ov2    = st2 && t2_tick && (cnt2 == 8'hFF);

`ifdef OPL2_FORCE_OVERFLOW_EN
  assign force_set = force_timer_overflow;
`else
  logic unused_force;
  assign unused_force = force_timer_overflow;
  assign force_set    = 1'b0;
`endif

  // Set beats clear when both land on the same edge.
  assign ft1_next = (ft1 && !wr_clr) || ((ov1 || force_set) && !mask1);
  assign ft2_next = (ft2 && !wr_clr) || ((ov2 || force_set) && !mask2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre       <= '0;
      sub       <= '0;
      t1_reload <= '0;
      t2_reload <= '0;
      cnt1      <= '0;
      cnt2      <= '0;
      mask1     <= 1'b0;
      mask2     <= 1'b0;
      st1       <= 1'b0;
      st2       <= 1'b0;
      ft1       <= 1'b0;
      ft2       <= 1'b0;
      status    <= '0;
      irq_n     <= 1'b1;
    end else begin
      pre <= t1_tick ? 12'd0 : pre + 12'd1;
      if (t1_tick) sub <= t2_tick ? 4'd0 : sub + 4'd1;

      if (start1)                cnt1 <= t1_reload;
      else if (st1 && t1_tick)   cnt1 <= ov1 ? t1_reload : cnt1 + 8'd1;
      if (start2)                cnt2 <= t2_reload;
      else if (st2 && t2_tick)   cnt2 <= ov2 ? t2_reload : cnt2 + 8'd1;

      if (opl2_reg_wr.valid && opl2_reg_wr.address == 8'h02) t1_reload <= opl2_reg_wr.data;
      if (opl2_reg_wr.valid && opl2_reg_wr.address == 8'h03) t2_reload <= opl2_reg_wr.data;
      if (wr_mode) begin
        mask1 <= opl2_reg_wr.data[6];
        mask2 <= opl2_reg_wr.data[5];
        st2   <= opl2_reg_wr.data[1];
        st1   <= opl2_reg_wr.data[0];
      end

      ft1    <= ft1_next;
      ft2    <= ft2_next;
      status <= {ft1_next || ft2_next, ft1_next, ft2_next, 5'b0};
      irq_n  <= !(ft1_next || ft2_next);
    end
  end

endmodule

// File: tb/tb_opl2_timer_status.sv
// tb/tb_opl2_timer_status.sv - scoreboard bench with a ticks-remaining reference model.
module tb_opl2_timer_status;
  import opl2_timer_pkg::*;

  localparam int DIV   = 4;
  localparam int RATIO = 4;

  typedef struct packed {
    logic [7:0] st;
    logic       irqn;
    logic       tick;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  opl2_reg_wr_t wr;
  logic         force_ov;
  logic [7:0]   status;
  logic         irq_n;
  logic         t1_tick;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int c, t1r, t2r, rem1, rem2;
  bit m1, m2, s1, s2, f1, f2;

  opl2_timer_status #(.CLK_DIV_80US(DIV), .T2_TICK_RATIO(RATIO)) dut (
    .clk                  (clk),
    .reset                (reset),
    .opl2_reg_wr          (wr),
    .force_timer_overflow (force_ov),
    .status               (status),
    .irq_n                (irq_n),
    .t1_tick              (t1_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, c);
    end
  endtask

  task automatic model_reset();
    c = 0; t1r = 0; t2r = 0; rem1 = 0; rem2 = 0;
    m1 = 0; m2 = 0; s1 = 0; s2 = 0; f1 = 0; f2 = 0;
  endtask

  // Timers are modelled as "ticks left until overflow"; ticks come from the cycle count since reset.
  task automatic model_step(input bit v, input bit [7:0] a, input bit [7:0] d, input bit f);
    bit tk1, tk2, ov1, ov2;
    tk1 = (c % DIV) == DIV - 1;
    tk2 = tk1 && ((c / DIV) % RATIO) == RATIO - 1;
    ov1 = 0;
    ov2 = 0;
    if (v && a == 8'h04 && !d[7] && d[0] && !s1) rem1 = 256 - t1r;
    else if (s1 && tk1) begin
      rem1--;
      if (rem1 == 0) begin ov1 = 1; rem1 = 256 - t1r; end
    end
    if (v && a == 8'h04 && !d[7] && d[1] && !s2) rem2 = 256 - t2r;
    else if (s2 && tk2) begin
      rem2--;
      if (rem2 == 0) begin ov2 = 1; rem2 = 256 - t2r; end
    end
    if (v && a == 8'h04 && d[7]) begin f1 = 0; f2 = 0; end
    if (ov1 && !m1) f1 = 1;
    if (ov2 && !m2) f2 = 1;
`ifdef OPL2_FORCE_OVERFLOW_EN
    if (f && !m1) f1 = 1;
    if (f && !m2) f2 = 1;
`endif
    if (v) begin
      if (a == 8'h02) t1r = d;
      if (a == 8'h03) t2r = d;
      if (a == 8'h04 && !d[7]) begin m1 = d[6]; m2 = d[5]; s2 = d[1]; s1 = d[0]; end
    end
    c++;
    q.push_back('{st: {f1 | f2, f1, f2, 5'b0}, irqn: !(f1 | f2), tick: (c % DIV) == DIV - 1});
  endtask

  task automatic cycle(input bit v, input bit [7:0] a, input bit [7:0] d, input bit f);
    wr.valid = v; wr.address = a; wr.data = d; force_ov = f;
    model_step(v, a, d, f);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 8'h00, 0);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (!reset && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("status", status, e.st);
      chk("irq_n", irq_n, e.irqn);
      chk("t1_tick", t1_tick, e.tick);
    end
  end

  initial begin
    wr = '0;
    force_ov = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_status", status, 8'h00);
    chk("reset_irq_n", irq_n, 1);
    chk("reset_t1_tick", t1_tick, 0);
    reset = 1'b0;

    // T1 with reload 0xFF overflows every tick; clear and watch it re-assert.
    cycle(1, 8'h02, 8'hFF, 0);
    cycle(1, 8'h04, 8'h01, 0);
    idle(6);
    cycle(1, 8'h04, 8'h80, 0);
    idle(9);
    // Clear landing exactly on an overflow cycle: set wins.
    while ((c % DIV) != DIV - 1) idle(1);
    cycle(1, 8'h04, 8'h80, 0);
    idle(3);
    // Masked T1 reloads silently.
    cycle(1, 8'h04, 8'h00, 0);
    cycle(1, 8'h04, 8'h80, 0);
    cycle(1, 8'h04, 8'h41, 0);
    idle(100);
    // T2 with reload 0xFE.
    cycle(1, 8'h04, 8'h00, 0);
    cycle(1, 8'h04, 8'h80, 0);
    cycle(1, 8'h03, 8'hFE, 0);
    cycle(1, 8'h04, 8'h02, 0);
    idle(50);
    // Stop mid-count, change reload, restart: reload from register.
    cycle(1, 8'h04, 8'h80, 0);
    cycle(1, 8'h02, 8'hF0, 0);
    cycle(1, 8'h04, 8'h01, 0);
    idle(20);
    cycle(1, 8'h04, 8'h00, 0);
    cycle(1, 8'h02, 8'hFC, 0);
    idle(50);
    cycle(1, 8'h04, 8'h01, 0);
    idle(40);
    // Force pulse with mask2 set.
    cycle(1, 8'h04, 8'h20, 0);
    cycle(1, 8'h04, 8'h80, 0);
    cycle(0, 8'h00, 8'h00, 1);
    idle(5);

    // Asynchronous reset mid-count.
    cycle(1, 8'h04, 8'h03, 0);
    idle(13);
    reset = 1'b1;
    #1;
    chk("async_status", status, 8'h00);
    chk("async_irq_n", irq_n, 1);
    chk("async_t1_tick", t1_tick, 0);
    q.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      bit v, f;
      bit [7:0] a, d;
      v = $urandom_range(0, 99) < 30;
      f = $urandom_range(0, 99) < 3;
      a = 8'h00;
      d = 8'($urandom);
      if (v) begin
        case ($urandom_range(0, 5))
          0: begin a = 8'h02; if ($urandom_range(0, 1) == 1) d = d | 8'hF8; end
          1: begin a = 8'h03; if ($urandom_range(0, 1) == 1) d = d | 8'hFC; end
          2, 3: begin a = 8'h04; d = d & 8'h7F; end
          4: begin a = 8'h04; d = d | 8'h80; end
          default: a = 8'($urandom);
        endcase
      end
      cycle(v, a, d, f);
    end

    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
